ex_stage_md: RTL

- Parametrised execute stage: combinational ALU path plus an iterative multiply/divide unit with architectural HI/LO registers.
- Stalls the front of the pipeline while a multi-cycle MULT/DIV is in flight.
- Generalises store-data forwarding to MEM and WB sources.
- Sits between the ID/EX and EX/MEM pipeline registers; feeds the CP0 overflow input.

---
 rtl/ex_pkg.sv | 60 ++++++
 rtl/md_unit.sv | 150 +++++++++++++++
 rtl/ex_stage_md.sv | 118 +++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   - ALU operation codes (alu_op)
//   - multiply/divide operation codes (md_op)
//   - result_sel and st_fwd_sel encodings
//   - multiply/divide sequencer states
package ex_pkg;

  // ALU operation codes carried down the pipeline from decode
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13
  } alu_op_e;

  // Multiply/divide unit operations
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  // Source of ex_result; encoding 3 falls back to the ALU
  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_HI  = 2'd1,
    RES_LO  = 2'd2
  } result_sel_e;

  // Source of the store data; encoding 3 also selects rt
  typedef enum logic [1:0] {
    ST_RT     = 2'd0,
    ST_MEM    = 2'd1,
    ST_WB     = 2'd2,
    ST_RT_ALT = 2'd3
  } st_fwd_sel_e;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit owning the architectural HI/LO.
//   clk, rst        : clock, synchronous active-high reset
//   exValid, exFlush: EX holds a real instruction / kill it this cycle
//   mdOp            : md_op code of the EX instruction
//   opA, opB        : rs_or_pc4 / rt_or_zero operands
//   hi, lo          : architectural HI/LO registers
//   stall           : hold the front of the pipeline
// Multiplies take MUL_CYCLES busy cycles after the start cycle; divides use a
// restoring radix-2 loop on operand magnitudes, one quotient bit per cycle.
module md_unit
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exValid,
  input  logic            exFlush,
  input  logic [2:0]      mdOp,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            stall
);

  // Wide enough for both XLEN-1 and MUL_CYCLES-1
  localparam int CNT_W = (($clog2(MUL_CYCLES) > $clog2(XLEN)) ?
                          $clog2(MUL_CYCLES) : $clog2(XLEN)) + 1;

  md_state_e         state, stateNext;
  logic [CNT_W-1:0]  count;
  logic              isDivOp, isMulDivOp, isSignedOp, start, mtWrite;
  logic              latchDiv, latchSigned, negQuot, negRem;
  logic [XLEN-1:0]   latchA, latchB, absA, absB;
  logic [XLEN-1:0]   divRem, divQuot, divisor, divTrial;
  logic [XLEN:0]     divShift;
  logic              divFits;
  logic [2*XLEN-1:0] extA, extB, product;
  logic [XLEN-1:0]   quotFinal, remFinal;

  assign isDivOp    = (mdOp == MD_DIV) || (mdOp == MD_DIVU);
  assign isMulDivOp = isDivOp || (mdOp == MD_MULT) || (mdOp == MD_MULTU);
  assign isSignedOp = (mdOp == MD_MULT) || (mdOp == MD_DIV);
  assign start      = (state == S_IDLE) && exValid && !exFlush && isMulDivOp;
  assign mtWrite    = (state == S_IDLE) && exValid && !exFlush &&
                      ((mdOp == MD_MTHI) || (mdOp == MD_MTLO));

  // Magnitudes for the divider; MIN maps onto itself, which is correct unsigned
  assign absA = (isSignedOp && opA[XLEN-1]) ? -opA : opA;
  assign absB = (isSignedOp && opB[XLEN-1]) ? -opB : opB;

  // Full product from the latched operands; the busy cycles model its latency
  assign extA    = latchSigned ? {{XLEN{latchA[XLEN-1]}}, latchA} : {{XLEN{1'b0}}, latchA};
  assign extB    = latchSigned ? {{XLEN{latchB[XLEN-1]}}, latchB} : {{XLEN{1'b0}}, latchB};
  assign product = extA * extB;

  // One restoring step: shift in the next dividend bit and try to subtract
  assign divShift = {divRem, divQuot[XLEN-1]};
  assign divFits  = divShift >= {1'b0, divisor};
  assign divTrial = divShift[XLEN-1:0] - divisor;

  // Sign fix-up; a zero divisor forces the all-ones quotient
  assign quotFinal = (divisor == '0) ? '1 : (negQuot ? -divQuot : divQuot);
  assign remFinal  = negRem ? -divRem : divRem;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and stall; the start cycle stalls before the state changes
  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          stall     = 1'b1;
          stateNext = isDivOp ? S_DIV : S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        stall = 1'b1;
        if (count == '0) begin
          stateNext = S_DONE;
        end
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
    if (exFlush) begin
      stateNext = S_IDLE;
    end
  end

  // Counter, operand latches and divider iteration
  always_ff @(posedge clk) begin
    if (rst || exFlush) begin
      count <= '0;
    end else if (start) begin
      count       <= isDivOp ? CNT_W'(XLEN - 1) : CNT_W'(MUL_CYCLES - 1);
      latchA      <= opA;
      latchB      <= opB;
      latchDiv    <= isDivOp;
      latchSigned <= isSignedOp;
      negQuot     <= isSignedOp && (opA[XLEN-1] ^ opB[XLEN-1]);
      negRem      <= isSignedOp && opA[XLEN-1];
      divRem      <= '0;
      divQuot     <= absA;
      divisor     <= absB;
    end else if (state == S_MUL) begin
      count <= count - CNT_W'(1);
    end else if (state == S_DIV) begin
      count   <= count - CNT_W'(1);
      divRem  <= divFits ? divTrial : divShift[XLEN-1:0];
      divQuot <= {divQuot[XLEN-2:0], divFits};
    end
  end

  // HI/LO update: retire a finished MULT/DIV, or an MTHI/MTLO move
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!exFlush) begin
      if (state == S_DONE) begin
        if (latchDiv) begin
          hi <= remFinal;
          lo <= quotFinal;
        end else begin
          hi <= product[2*XLEN-1:XLEN];
          lo <= product[XLEN-1:0];
        end
      end else if (mtWrite) begin
        if (mdOp == MD_MTHI) begin
          hi <= opA;
        end else begin
          lo <= opA;
        end
      end
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with a combinational ALU and an iterative
// multiply/divide unit.
//   clk, rst               : clock, synchronous active-high reset
//   ex_valid, ex_flush     : real instruction in EX / kill it
//   alu_op, md_op          : operation codes (ex_pkg)
//   result_sel             : ALU, HI or LO onto ex_result
//   a_use_shamt, b_use_imm : ALU operand selects
//   immediate, rs_or_pc4, rt_or_zero : operand sources
//   st_fwd_sel, mem_data, wb_data    : store-data forwarding
//   ex_result, ex_store_data, ex_overflow : combinational results
//   ex_stall               : hold PC/IF/ID/ID-EX during a MULT/DIV
//   hi, lo                 : current HI/LO
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_flush,
  input  logic [3:0]      alu_op,
  input  logic [2:0]      md_op,
  input  logic [1:0]      result_sel,
  input  logic            a_use_shamt,
  input  logic            b_use_imm,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] rs_or_pc4,
  input  logic [XLEN-1:0] rt_or_zero,
  input  logic [1:0]      st_fwd_sel,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_overflow,
  output logic            ex_stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [XLEN-1:0]    aluA, aluB, aluSum, aluDiff, aluResult;
  logic [SHAMT_W-1:0] shamt;
  logic               addOvf, subOvf;

  // The shamt field sits just above the 6-bit function field of the immediate
  assign aluA    = a_use_shamt ? {{(XLEN-SHAMT_W){1'b0}}, immediate[SHAMT_W+5:6]} : rs_or_pc4;
  assign aluB    = b_use_imm ? immediate : rt_or_zero;
  assign shamt   = aluA[SHAMT_W-1:0];
  assign aluSum  = aluA + aluB;
  assign aluDiff = aluA - aluB;

  // Signed overflow: operand signs agree (ADD) or differ (SUB) and the result flips
  assign addOvf = (aluA[XLEN-1] == aluB[XLEN-1]) && (aluSum[XLEN-1]  != aluA[XLEN-1]);
  assign subOvf = (aluA[XLEN-1] != aluB[XLEN-1]) && (aluDiff[XLEN-1] != aluA[XLEN-1]);

  assign ex_overflow = ex_valid && (((alu_op == ALU_ADD) && addOvf) ||
                                    ((alu_op == ALU_SUB) && subOvf));

  // ALU operation select; shifts move B by the amount in A
  always_comb begin
    aluResult = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD, ALU_ADDU: aluResult = aluSum;
      ALU_SUB, ALU_SUBU: aluResult = aluDiff;
      ALU_AND:           aluResult = aluA & aluB;
      ALU_OR:            aluResult = aluA | aluB;
      ALU_XOR:           aluResult = aluA ^ aluB;
      ALU_NOR:           aluResult = ~(aluA | aluB);
      ALU_SLT:           aluResult = {{(XLEN-1){1'b0}}, ($signed(aluA) < $signed(aluB))};
      ALU_SLTU:          aluResult = {{(XLEN-1){1'b0}}, (aluA < aluB)};
      ALU_SLL:           aluResult = aluB << shamt;
      ALU_SRL:           aluResult = aluB >> shamt;
      ALU_SRA:           aluResult = $signed(aluB) >>> shamt;
      ALU_LUI:           aluResult = aluB << (XLEN / 2);
      default:           aluResult = '0;
    endcase
  end

  // Result select: HI/LO reads see the registered values
  always_comb begin
    ex_result = aluResult;
    case (result_sel)
      RES_HI:  ex_result = hi;
      RES_LO:  ex_result = lo;
      default: ex_result = aluResult;
    endcase
  end

  // Store data forwarding from MEM or WB
  always_comb begin
    ex_store_data = rt_or_zero;
    case (st_fwd_sel)
      ST_MEM:  ex_store_data = mem_data;
      ST_WB:   ex_store_data = wb_data;
      default: ex_store_data = rt_or_zero;
    endcase
  end

  md_unit #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) mdUnit (
    .clk     (clk),
    .rst     (rst),
    .exValid (ex_valid),
    .exFlush (ex_flush),
    .mdOp    (md_op),
    .opA     (rs_or_pc4),
    .opB     (rt_or_zero),
    .hi      (hi),
    .lo      (lo),
    .stall   (ex_stall)
  );

endmodule
